// File: rtl/ahb_resp_mux.sv
// AHB-Lite slave response multiplexer with registered data-phase select and saturating error counter.
// Define AHB_RESP_MUX_DEFAULT_SLAVE_EN to build in the two-cycle ERROR default slave for unmapped transfers.
module ahb_resp_mux #(
  parameter int NUM_SLAVES = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_hsel    [NUM_SLAVES],
  input  logic [1:0]            i_htrans,
  input  logic [DATA_WIDTH-1:0] i_shrdata [NUM_SLAVES],
  input  logic [NUM_SLAVES-1:0] i_shresp,
  input  logic [NUM_SLAVES-1:0] i_shready,
  output logic [DATA_WIDTH-1:0] o_mhrdata,
  output logic                  o_mhresp,
  output logic                  o_mhready,
  output logic [NUM_SLAVES-1:0] o_dp_sel,
  output logic [7:0]            o_err_cnt
);

  logic [NUM_SLAVES-1:0] hsel_vec;
  logic [NUM_SLAVES-1:0] dp_sel;
  logic                  accept;
  logic [DATA_WIDTH-1:0] slave_rdata;
  logic                  slave_resp;
  logic                  slave_ready;
  logic                  unused_htrans;

  always_comb begin
    hsel_vec = '0;
    for (int i = 0; i < NUM_SLAVES; i++) hsel_vec[i] = i_hsel[i];
  end

  assign accept   = o_mhready;
  assign o_dp_sel = dp_sel;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) dp_sel <= '0;
    else if (accept) dp_sel <= hsel_vec;
  end

  // Scan from the top down so the lowest selected index is the one left standing.
  always_comb begin
    slave_rdata = '0;
    slave_resp  = 1'b0;
    slave_ready = 1'b1;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (dp_sel[i]) begin
        slave_rdata = i_shrdata[i];
        slave_resp  = i_shresp[i];
        slave_ready = i_shready[i];
      end
    end
  end

`ifdef AHB_RESP_MUX_DEFAULT_SLAVE_EN
  typedef enum logic [1:0] {IDLE, ERR1, ERR2} state_t;

  state_t state;
  logic   ds_active;
  logic   ds_ready;
  logic   unmapped_req;

  assign unmapped_req  = i_htrans[1] && (hsel_vec == '0);
  assign unused_htrans = i_htrans[0];

  // ds_active/ds_ready are registered alongside the state so the override needs no decode.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      ds_active <= 1'b0;
      ds_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (accept && unmapped_req) begin
            state     <= ERR1;
            ds_active <= 1'b1;
            ds_ready  <= 1'b0;
          end
        end
        ERR1: begin
          state     <= ERR2;
          ds_active <= 1'b1;
          ds_ready  <= 1'b1;
        end
        ERR2: begin
          if (accept && unmapped_req) begin
            state     <= ERR1;
            ds_active <= 1'b1;
            ds_ready  <= 1'b0;
          end else begin
            state     <= IDLE;
            ds_active <= 1'b0;
            ds_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          ds_active <= 1'b0;
          ds_ready  <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    if (ds_active) begin
      o_mhrdata = '0;
      o_mhresp  = 1'b1;
      o_mhready = ds_ready;
    end else begin
      o_mhrdata = slave_rdata;
      o_mhresp  = slave_resp;
      o_mhready = slave_ready;
    end
  end
`else
  assign unused_htrans = ^i_htrans;

  always_comb begin
    o_mhrdata = slave_rdata;
    o_mhresp  = slave_resp;
    o_mhready = slave_ready;
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_err_cnt <= 8'd0;
    else if (o_mhready && o_mhresp && (o_err_cnt != 8'hFF)) o_err_cnt <= o_err_cnt + 8'd1;
  end

endmodule

// File: tb/tb_ahb_resp_mux.sv
// Self-checking bench for ahb_resp_mux: vector table, directed multi-cycle sequences, randomized model check.
// Expectations follow AHB_RESP_MUX_DEFAULT_SLAVE_EN when it is defined for the build.
module tb_ahb_resp_mux;
  localparam int NS = 4;
  localparam int DW = 32;
`ifdef AHB_RESP_MUX_DEFAULT_SLAVE_EN
  localparam bit DS_EN = 1'b1;
`else
  localparam bit DS_EN = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          hsel    [NS];
  logic [1:0]    htrans;
  logic [DW-1:0] shrdata [NS];
  logic [NS-1:0] shresp;
  logic [NS-1:0] shready;
  logic [DW-1:0] mhrdata;
  logic          mhresp;
  logic          mhready;
  logic [NS-1:0] dp_sel;
  logic [7:0]    err_cnt;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [3:0]  sel;
    logic [1:0]  trans;
    logic [3:0]  rdy;
    logic [3:0]  rsp;
    logic [31:0] e_rdata;
    logic        e_resp;
    logic        e_ready;
    logic [3:0]  e_dp;
    logic [7:0]  e_cnt;
  } vec_t;

  vec_t vecs [13];

  ahb_resp_mux #(.NUM_SLAVES(NS), .DATA_WIDTH(DW)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_hsel    (hsel),
    .i_htrans  (htrans),
    .i_shrdata (shrdata),
    .i_shresp  (shresp),
    .i_shready (shready),
    .o_mhrdata (mhrdata),
    .o_mhresp  (mhresp),
    .o_mhready (mhready),
    .o_dp_sel  (dp_sel),
    .o_err_cnt (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; slave i returns C0DE_000i except slave 2, which returns A5A5_0001.
  task automatic applyStimulus(input logic [3:0] sel, input logic [1:0] trans,
                               input logic [3:0] rdy, input logic [3:0] rsp);
    @(negedge clk);
    for (int i = 0; i < NS; i++) begin
      hsel[i]    = sel[i];
      shrdata[i] = 32'hC0DE_0000 | 32'(i);
    end
    shrdata[2] = 32'hA5A5_0001;
    htrans     = trans;
    shready    = rdy;
    shresp     = rsp;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] er, input logic eresp,
                             input logic erdy, input logic [3:0] edp, input logic [7:0] ecnt);
    compared++;
    if (mhrdata !== er || mhresp !== eresp || mhready !== erdy || dp_sel !== edp || err_cnt !== ecnt) begin
      mismatched++;
      $display("[TB] FAIL %s: got rdata=%h resp=%b ready=%b dp_sel=%b err_cnt=%0d, want rdata=%h resp=%b ready=%b dp_sel=%b err_cnt=%0d",
               name, mhrdata, mhresp, mhready, dp_sel, err_cnt, er, eresp, erdy, edp, ecnt);
    end
  endtask

  initial begin
    logic [7:0]  cnt;
    logic [3:0]  m_dp;
    int          m_err;
    logic [7:0]  m_cnt;
    logic [3:0]  rsel;
    logic [3:0]  rrdy;
    logic [3:0]  rrsp;
    logic [31:0] e_rdata;
    logic        e_resp;
    logic        e_ready;
    int          idx;

    vecs[0]  = '{4'b0100, 2'b10, 4'hF,    4'h0,    32'h0,         1'b0, 1'b1, 4'b0000, 8'd0};
    vecs[1]  = '{4'b0000, 2'b00, 4'b1011, 4'h0,    32'hA5A5_0001, 1'b0, 1'b0, 4'b0100, 8'd0};
    vecs[2]  = '{4'b0000, 2'b00, 4'b1011, 4'h0,    32'hA5A5_0001, 1'b0, 1'b0, 4'b0100, 8'd0};
    vecs[3]  = '{4'b0000, 2'b00, 4'hF,    4'h0,    32'hA5A5_0001, 1'b0, 1'b1, 4'b0100, 8'd0};
    vecs[4]  = '{4'b0001, 2'b10, 4'hF,    4'h0,    32'h0,         1'b0, 1'b1, 4'b0000, 8'd0};
    vecs[5]  = '{4'b0010, 2'b10, 4'hF,    4'h0,    32'hC0DE_0000, 1'b0, 1'b1, 4'b0001, 8'd0};
    vecs[6]  = '{4'b0000, 2'b00, 4'hF,    4'h0,    32'hC0DE_0001, 1'b0, 1'b1, 4'b0010, 8'd0};
    vecs[7]  = '{4'b0000, 2'b01, 4'hF,    4'h0,    32'h0,         1'b0, 1'b1, 4'b0000, 8'd0};
    vecs[8]  = '{4'b1000, 2'b10, 4'hF,    4'h0,    32'h0,         1'b0, 1'b1, 4'b0000, 8'd0};
    vecs[9]  = '{4'b0000, 2'b00, 4'hF,    4'b1000, 32'hC0DE_0003, 1'b1, 1'b1, 4'b1000, 8'd0};
    vecs[10] = '{4'b0110, 2'b10, 4'hF,    4'h0,    32'h0,         1'b0, 1'b1, 4'b0000, 8'd1};
    vecs[11] = '{4'b0000, 2'b00, 4'hF,    4'h0,    32'hC0DE_0001, 1'b0, 1'b1, 4'b0110, 8'd1};
    vecs[12] = '{4'b0000, 2'b00, 4'hF,    4'h0,    32'h0,         1'b0, 1'b1, 4'b0000, 8'd1};

    rst_n = 1'b0;
    for (int i = 0; i < NS; i++) begin
      hsel[i]    = 1'b0;
      shrdata[i] = 32'hFFFF_FFFF;
    end
    htrans  = 2'b00;
    shready = 4'hF;
    shresp  = 4'hF;
    #1;
    checkOutput("reset_state", 32'h0, 1'b0, 1'b1, 4'b0000, 8'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 13; k++) begin
      applyStimulus(vecs[k].sel, vecs[k].trans, vecs[k].rdy, vecs[k].rsp);
      checkOutput($sformatf("vec%0d", k), vecs[k].e_rdata, vecs[k].e_resp, vecs[k].e_ready,
                  vecs[k].e_dp, vecs[k].e_cnt);
    end

    // Single unmapped NONSEQ.
    cnt = 8'd1;
    applyStimulus(4'b0000, 2'b10, 4'hF, 4'h0);
    checkOutput("unmapped_addr", 32'h0, 1'b0, 1'b1, 4'b0000, cnt);
    applyStimulus(4'b0000, 2'b00, 4'hF, 4'h0);
    checkOutput("unmapped_err1", 32'h0, DS_EN, !DS_EN, 4'b0000, cnt);
    applyStimulus(4'b0000, 2'b00, 4'hF, 4'h0);
    checkOutput("unmapped_err2", 32'h0, DS_EN, 1'b1, 4'b0000, cnt);
    if (DS_EN) cnt = cnt + 8'd1;
    applyStimulus(4'b0000, 2'b00, 4'hF, 4'h0);
    checkOutput("unmapped_done", 32'h0, 1'b0, 1'b1, 4'b0000, cnt);

    // Two consecutive unmapped NONSEQs; the second is held through ERR1 and accepted in ERR2.
    applyStimulus(4'b0000, 2'b10, 4'hF, 4'h0);
    checkOutput("b2b_addr", 32'h0, 1'b0, 1'b1, 4'b0000, cnt);
    applyStimulus(4'b0000, 2'b10, 4'hF, 4'h0);
    checkOutput("b2b_err1a", 32'h0, DS_EN, !DS_EN, 4'b0000, cnt);
    applyStimulus(4'b0000, 2'b10, 4'hF, 4'h0);
    checkOutput("b2b_err2a", 32'h0, DS_EN, 1'b1, 4'b0000, cnt);
    if (DS_EN) cnt = cnt + 8'd1;
    applyStimulus(4'b0000, 2'b00, 4'hF, 4'h0);
    checkOutput("b2b_err1b", 32'h0, DS_EN, !DS_EN, 4'b0000, cnt);
    applyStimulus(4'b0000, 2'b00, 4'hF, 4'h0);
    checkOutput("b2b_err2b", 32'h0, DS_EN, 1'b1, 4'b0000, cnt);
    if (DS_EN) cnt = cnt + 8'd1;
    applyStimulus(4'b0000, 2'b00, 4'hF, 4'h0);
    checkOutput("b2b_done", 32'h0, 1'b0, 1'b1, 4'b0000, cnt);

    // Saturation: slave 3 answers ERROR on every cycle.
    for (int n = 0; n < 260; n++) applyStimulus(4'b1000, 2'b10, 4'hF, 4'b1000);
    applyStimulus(4'b0000, 2'b00, 4'hF, 4'h0);
    checkOutput("err_cnt_saturate", 32'hC0DE_0003, 1'b0, 1'b1, 4'b1000, 8'd255);

    // Reset while slave 2 is stalling its data phase.
    applyStimulus(4'b0100, 2'b10, 4'hF, 4'h0);
    applyStimulus(4'b0000, 2'b00, 4'b1011, 4'h0);
    checkOutput("stall_before_rst", 32'hA5A5_0001, 1'b0, 1'b0, 4'b0100, 8'd255);
    rst_n = 1'b0;
    #1;
    checkOutput("stall_async_rst", 32'h0, 1'b0, 1'b1, 4'b0000, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(4'b0000, 2'b00, 4'hF, 4'h0);
    checkOutput("stall_after_rst", 32'h0, 1'b0, 1'b1, 4'b0000, 8'd0);

    // Reset in the middle of the first error cycle.
    applyStimulus(4'b0000, 2'b10, 4'hF, 4'h0);
    applyStimulus(4'b0000, 2'b00, 4'hF, 4'h0);
    checkOutput("err1_before_rst", 32'h0, DS_EN, !DS_EN, 4'b0000, 8'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("err1_async_rst", 32'h0, 1'b0, 1'b1, 4'b0000, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(4'b0000, 2'b00, 4'hF, 4'h0);
    applyStimulus(4'b0000, 2'b00, 4'hF, 4'h0);
    checkOutput("err1_after_rst", 32'h0, 1'b0, 1'b1, 4'b0000, 8'd0);

    // Randomized run against a transaction-level model of the bus.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    m_dp  = 4'b0000;
    m_err = 0;
    m_cnt = 8'd0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      idx = int'($urandom_range(0, 9));
      if (idx < 4) rsel = 4'b0000;
      else if (idx < 9) rsel = 4'b0001 << $urandom_range(0, 3);
      else rsel = 4'($urandom_range(1, 15));
      for (int i = 0; i < NS; i++) begin
        rrdy[i]    = ($urandom_range(0, 3) != 0);
        rrsp[i]    = ($urandom_range(0, 7) == 0);
        hsel[i]    = rsel[i];
        shrdata[i] = $urandom;
      end
      htrans  = 2'($urandom_range(0, 3));
      shready = rrdy;
      shresp  = rrsp;
      #1;
      if (m_err == 1) begin
        e_rdata = 32'h0; e_resp = 1'b1; e_ready = 1'b0;
      end else if (m_err == 2) begin
        e_rdata = 32'h0; e_resp = 1'b1; e_ready = 1'b1;
      end else begin
        idx = -1;
        for (int i = 0; i < NS; i++) if (m_dp[i] && idx < 0) idx = i;
        if (idx >= 0) begin
          e_rdata = shrdata[idx]; e_resp = rrsp[idx]; e_ready = rrdy[idx];
        end else begin
          e_rdata = 32'h0; e_resp = 1'b0; e_ready = 1'b1;
        end
      end
      checkOutput($sformatf("rand%0d", n), e_rdata, e_resp, e_ready, m_dp, m_cnt);
      @(posedge clk);
      if (e_ready && e_resp && m_cnt < 8'd255) m_cnt = m_cnt + 8'd1;
      if (e_ready) begin
        m_dp  = rsel;
        m_err = (DS_EN && htrans[1] && rsel == 4'b0000) ? 1 : 0;
      end else if (m_err == 1) begin
        m_err = 2;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ahb_resp_mux.md
AHB_RESP_MUX -- requirements
Module: ahb_resp_mux

Interface
REQ-001 Parameter NUM_SLAVES, default 4, number of slave response channels (range 1..16).
REQ-002 Parameter DATA_WIDTH, default 32, read-data width in bits.
REQ-003 i_clk  input  1  bus clock; all state updates on the rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 i_hsel  input  1 x NUM_SLAVES (unpacked)  address-phase slave select, one-hot or zero.
REQ-006 i_htrans  input  2  address-phase transfer type from the master.
REQ-007 i_shrdata  input  DATA_WIDTH x NUM_SLAVES  hrdata from each slave.
REQ-008 i_shresp  input  1 x NUM_SLAVES  hresp from each slave (1 = ERROR).
REQ-009 i_shready  input  1 x NUM_SLAVES  hreadyout from each slave.
REQ-010 o_mhrdata  output  DATA_WIDTH  hrdata to the master.
REQ-011 o_mhresp  output  1  hresp to the master.
REQ-012 o_mhready  output  1  hready to the master and to all slaves.
REQ-013 o_dp_sel  output  NUM_SLAVES  registered data-phase select, for debug.
REQ-014 o_err_cnt  output  8  saturating count of completed ERROR responses.

Function
REQ-015 Accept = o_mhready==1 at a rising edge; dp_sel SHALL load i_hsel on accept and hold otherwise.
REQ-016 When dp_sel bit i is set, o_mhrdata/o_mhresp/o_mhready SHALL equal i_shrdata[i]/i_shresp[i]/i_shready[i] combinationally, with zero added latency.
REQ-017 If dp_sel is multi-hot, the lowest set index SHALL win.
REQ-018 With dp_sel zero and the default-slave FSM in IDLE, outputs SHALL be rdata 0, resp 0, ready 1.
REQ-019 Data-phase selection SHALL lag address-phase i_hsel by exactly one accepted cycle; wait states stretch the lag.
REQ-020 Default-slave FSM states: IDLE, ERR1, ERR2.
REQ-021 IDLE -> ERR1 on accept with i_htrans[1]==1 and i_hsel all zero; otherwise stay in IDLE.
REQ-022 ERR1 SHALL drive ready 0, resp 1, rdata 0, then move unconditionally to ERR2.
REQ-023 ERR2 SHALL drive ready 1, resp 1, rdata 0.
REQ-024 ERR2 SHALL move to ERR1 if the concurrent accept is another unmapped NONSEQ/SEQ; otherwise it SHALL return to IDLE.
REQ-025 FSM outputs SHALL override dp_sel muxing while in ERR1/ERR2.
REQ-026 IDLE/BUSY (i_htrans[1]==0) to no slave SHALL receive a zero-wait OKAY.
REQ-027 o_err_cnt SHALL increment when o_mhready==1 and o_mhresp==1 at a rising edge, whatever the source.
REQ-028 o_err_cnt SHALL saturate at 255.

Reset
REQ-029 Assertion of i_rst_n low SHALL immediately clear dp_sel and o_err_cnt, force the FSM to IDLE, and drive o_mhrdata=0, o_mhresp=0, o_mhready=1.
REQ-030 Reset mid-transfer SHALL abandon the in-flight data phase; the first accept after release starts fresh.

Configuration
REQ-031 Macro AHB_RESP_MUX_DEFAULT_SLAVE_EN defined SHALL compile in the ERR1/ERR2 default-slave FSM per REQ-020..025.
REQ-032 Without the macro, unmapped transfers SHALL get a zero-wait OKAY with rdata 0; the FSM SHALL be absent and o_err_cnt SHALL count slave errors only.

Verification
REQ-033 Write slave 2 (i_hsel[2]=1, NONSEQ), i_shready[2]=0 for 2 cycles, i_shrdata[2]=0xA5A5_0001 -> o_mhready 0,0,1, then o_mhrdata=0xA5A5_0001, o_dp_sel=4'b0100.
REQ-034 Back-to-back NONSEQ to slave 0 then slave 1 -> o_mhrdata follows slave 0 in cycle n+1 and slave 1 in cycle n+2.
REQ-035 Macro on, NONSEQ with i_hsel=0 -> next cycle ready 0/resp 1, following cycle ready 1/resp 1, then IDLE; o_err_cnt 0 -> 1.
REQ-036 Macro on, two consecutive unmapped NONSEQs -> sequence ERR1,ERR2,ERR1,ERR2; o_err_cnt=2.
REQ-037 Force 256 slave ERRORs (i_shresp[3]=1) -> o_err_cnt holds 255.
REQ-038 Assert i_rst_n low during an ERR1 cycle -> outputs immediately 0/0/1, o_err_cnt=0, next unmapped IDLE transfer gets OKAY.
